// File: rtl/compare_seq.sv
// compare_seq: sequential A<B engine, scanning DIGIT bits per cycle MSB-first until the first differing digit.
// Optional `COMPARE_SEQ_EQ_EN adds o_eq, a registered all-digits-equal flag alongside o_result.
module compare_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_vld,
    output logic             o_start_rdy,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_res_vld,
    input  logic             i_res_rdy,
`ifdef COMPARE_SEQ_EQ_EN
    output logic             o_eq,
`endif
    output logic [31:0]      o_result
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("compare_seq: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             result_q,  result_d;
    logic             res_vld_q, res_vld_d;
`ifdef COMPARE_SEQ_EQ_EN
    logic             eq_q,      eq_d;
`endif

    logic [WIDTH-1:0] sign_mask;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;

    function automatic logic [DIGIT-1:0] digit_at(input logic [WIDTH-1:0] v,
                                                   input logic [IDX_W-1:0] idx);
        logic [DIGIT-1:0] d;
        d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) d = v[i*DIGIT +: DIGIT];
        end
        return d;
    endfunction

    assign o_start_rdy = (state_q == IDLE);
    assign o_res_vld   = res_vld_q;
    assign o_result    = {{31{1'b0}}, result_q};
`ifdef COMPARE_SEQ_EQ_EN
    assign o_eq        = eq_q;
`endif

    always_comb begin
        sign_mask          = '0;
        sign_mask[WIDTH-1] = i_signed;
        da                 = digit_at(a_q, idx_q);
        db                 = digit_at(b_q, idx_q);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        res_vld_d = res_vld_q;
`ifdef COMPARE_SEQ_EQ_EN
        eq_d      = eq_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start_vld) begin
                    // Flipping the sign bits maps two's-complement order onto unsigned order.
                    a_d     = i_a ^ sign_mask;
                    b_d     = i_b ^ sign_mask;
                    idx_d   = LAST_IDX;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (da != db) begin
                    result_d  = (da < db);
                    res_vld_d = 1'b1;
`ifdef COMPARE_SEQ_EQ_EN
                    eq_d      = 1'b0;
`endif
                    state_d   = DONE;
                end else if (idx_q == '0) begin
                    result_d  = 1'b0;
                    res_vld_d = 1'b1;
`ifdef COMPARE_SEQ_EQ_EN
                    eq_d      = 1'b1;
`endif
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (i_res_rdy) begin
                    res_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                res_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= 1'b0;
            res_vld_q <= 1'b0;
`ifdef COMPARE_SEQ_EQ_EN
            eq_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            res_vld_q <= res_vld_d;
`ifdef COMPARE_SEQ_EQ_EN
            eq_q      <= eq_d;
`endif
        end
    end

endmodule
